ahfp_cvt_arbiter: RTL and testbench

- Shares one `ahfp_fixed_2_float` converter between two requesters.
- The converter is combinational, maps 32-bit fixed to IEEE-754 single, and is instantiated internally.
- The block does round-robin arbitration, registers the operand and the result in a 2-stage pipeline, and presents a tagged result stream with back-pressure.
- It sits between the Nios-side request logic and the float datapath.

---
 rtl/ahfp_cvt_arbiter.sv | 135 +++++++++++++
 tb/tb_ahfp_cvt_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahfp_cvt_arbiter.sv
// ahfp_cvt_arbiter: two requesters share one fixed-to-float converter.
// Round-robin grant into stage A (operand), conversion between A and B,
// stage B is the registered result stream with valid/ready back-pressure.
//
// Handshakes:
//   Request side: reqN stays high with dataN stable until ackN. ackN is a
//   combinational single-cycle pulse (req/out_ready/state -> ack). The
//   operand is taken on the clock edge that ends the ack cycle.
//   Result side: the transfer happens on an edge where out_valid and
//   out_ready are both high. out_data/out_id are registered and stay stable
//   while out_valid is high and out_ready is low.

// Combinational signed fixed-point (2.29 two's complement) to IEEE-754
// single, round-to-nearest-even. 0x20000000 = 1.0 -> 0x3F800000.
module ahfp_fixed_2_float (
    input  logic [31:0] i_fixed,
    output logic [31:0] o_float
);
    logic        w_sign;
    logic [31:0] w_mag;
    logic [4:0]  w_pos;
    logic [30:0] w_norm;
    logic        w_round_up;
    logic [30:0] w_exp_mant;

    // Leading-one detect, normalise, then round the 23-bit mantissa.
    always_comb begin
        w_sign = i_fixed[31];
        w_mag  = w_sign ? (~i_fixed + 32'd1) : i_fixed;
        w_pos  = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (w_mag[i]) w_pos = 5'(i);
        end
        // Shift the leading one to bit 31, which is dropped (implicit one).
        w_norm     = 31'(w_mag << (5'd31 - w_pos));
        w_round_up = w_norm[7] & ((|w_norm[6:0]) | w_norm[8]);
        // Binary point sits above bit 29, so exponent = pos - 29 + 127.
        // A mantissa carry from rounding propagates into the exponent.
        w_exp_mant = {({3'b000, w_pos} + 8'd98), w_norm[30:8]} + {30'd0, w_round_up};
        if (w_mag == 32'd0) begin
            o_float = 32'd0;
        end else begin
            o_float = {w_sign, w_exp_mant};
        end
    end
endmodule

module ahfp_cvt_arbiter #(
    parameter int ID_W = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0,
    input  logic [31:0]     data0,
    output logic            ack0,
    input  logic            req1,
    input  logic [31:0]     data1,
    output logic            ack1,
    output logic            out_valid,
    output logic [31:0]     out_data,
    output logic [ID_W-1:0] out_id,
    input  logic            out_ready
);
    logic [31:0]     r_a_op;
    logic [ID_W-1:0] r_a_id;
    logic            r_a_valid;
    logic            r_last_grant;
    logic [31:0]     r_out_data;
    logic [ID_W-1:0] r_out_id;
    logic            r_out_valid;

    logic            w_b_adv;
    logic            w_a_adv;
    logic            w_a_free;
    logic            w_gnt0;
    logic            w_gnt1;
    logic [ID_W-1:0] w_sel;
    logic [31:0]     w_sel_data;
    logic [31:0]     w_float;

    ahfp_fixed_2_float u_cvt (
        .i_fixed (r_a_op),
        .o_float (w_float)
    );

    // Stall chain and round-robin grant; ties go to the index != last grant.
    // Acks are gated by reset_n so none are seen while reset is held.
    always_comb begin
        w_b_adv    = !r_out_valid | out_ready;
        w_a_adv    = r_a_valid & w_b_adv;
        w_a_free   = !r_a_valid | w_b_adv;
        w_gnt0     = reset_n & w_a_free & req0 & (!req1 | r_last_grant);
        w_gnt1     = reset_n & w_a_free & req1 & (!req0 | !r_last_grant);
        w_sel      = ID_W'(w_gnt1);
        w_sel_data = w_gnt1 ? data1 : data0;
    end

    // Stage A: capture the granted operand, or empty when free and idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_op       <= 32'd0;
            r_a_id       <= '0;
            r_a_valid    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_a_free) begin
            r_a_valid <= w_gnt0 | w_gnt1;
            if (w_gnt0 | w_gnt1) begin
                r_a_op       <= w_sel_data;
                r_a_id       <= w_sel;
                r_last_grant <= w_gnt1;
            end
        end
    end

    // Stage B: register the converted result; holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= 32'd0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_a_adv) begin
            r_out_data  <= w_float;
            r_out_id    <= r_a_id;
            r_out_valid <= 1'b1;
        end else if (w_b_adv) begin
            r_out_valid <= 1'b0;
        end
    end

    assign ack0      = w_gnt0;
    assign ack1      = w_gnt1;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
endmodule

// File: tb/tb_ahfp_cvt_arbiter.sv
// Bench for ahfp_cvt_arbiter: requester drivers fed from operand queues,
// expected results pushed on ack, popped when a result is accepted.
module tb_ahfp_cvt_arbiter;
  logic        clk;
  logic        reset_n;
  logic        req0, req1, ack0, ack1;
  logic [31:0] data0, data1;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_id;

  ahfp_cvt_arbiter #(.ID_W(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .data0     (data0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .ack1      (ack1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  logic [31:0] src0_q[$];
  logic [31:0] src1_q[$];
  logic [32:0] exp_q[$];
  int          ack_log[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          inflight = 0;
  logic        rdy = 1'b1;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_out = '0;
  logic        s_ack0, s_ack1, s_ov, s_oid;
  logic [31:0] s_od;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Known-good conversions (hand-derived IEEE-754 encodings).
  function automatic logic [31:0] ref_float(input logic [31:0] f);
    case (f)
      32'h20000000: return 32'h3F800000; // 1.0
      32'h40000000: return 32'h40000000; // 2.0
      32'h10000000: return 32'h3F000000; // 0.5
      32'h00000000: return 32'h00000000; // 0
      32'hE0000000: return 32'hBF800000; // -1.0
      32'h30000000: return 32'h3FC00000; // 1.5
      32'h00000001: return 32'h31000000; // 2^-29
      32'h7FFFFFFF: return 32'h40800000; // 4 - 2^-29 rounds up to 4.0
      32'h80000000: return 32'hC0800000; // -4.0
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  logic [31:0] tab[9];
  initial begin
    tab[0] = 32'h20000000; tab[1] = 32'h40000000; tab[2] = 32'h10000000;
    tab[3] = 32'h00000000; tab[4] = 32'hE0000000; tab[5] = 32'h30000000;
    tab[6] = 32'h00000001; tab[7] = 32'h7FFFFFFF; tab[8] = 32'h80000000;
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    src0_q.delete(); src1_q.delete(); exp_q.delete();
    inflight = 0; prev_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One cycle: drive at negedge, sample 1ns later (well before the posedge).
  task automatic step();
    @(negedge clk);
    req0 = (src0_q.size() > 0);
    data0 = req0 ? src0_q[0] : 32'h0;
    req1 = (src1_q.size() > 0);
    data1 = req1 ? src1_q[0] : 32'h0;
    out_ready = rdy;
    #1;
    s_ack0 = ack0; s_ack1 = ack1; s_ov = out_valid; s_od = out_data; s_oid = out_id;
    chk("ack_onehot", {63'd0, ack0 & ack1}, 64'd0);
    if (out_valid && !out_ready && inflight == 2)
      chk("stall_noack", {63'd0, ack0 | ack1}, 64'd0);
    if (prev_stall)
      chk("stall_hold", {30'd0, out_valid, out_id, out_data}, {30'd0, 1'b1, prev_out});
    if (ack0 && req0) begin
      exp_q.push_back({1'b0, ref_float(src0_q[0])});
      void'(src0_q.pop_front());
      ack_log.push_back(0);
      inflight++;
    end
    if (ack1 && req1) begin
      exp_q.push_back({1'b1, ref_float(src1_q[0])});
      void'(src1_q.pop_front());
      ack_log.push_back(1);
      inflight++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'd0, out_id, out_data}, 64'd0 - 1);
      end else begin
        chk("out", {31'd0, out_id, out_data}, {31'd0, exp_q.pop_front()});
      end
      inflight--;
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_id, out_data};
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy = 1'b1;
    while ((src0_q.size() > 0 || src1_q.size() > 0 || exp_q.size() > 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_done", {32'd0, 31'd0, (exp_q.size() == 0)}, 64'd1);
  endtask

  // ---------------- tests ----------------
  initial begin
    int n;
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; out_ready = 1'b1;
    #1;
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_od", {32'd0, out_data}, 64'd0);
    chk("rst_oid", {63'd0, out_id}, 64'd0);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("rst_noack", {62'd0, ack0, ack1}, 64'd0);
    do_reset();

    // Single operand latency.
    rdy = 1'b1;
    src0_q.push_back(32'h20000000);
    step(); chk("t1_ack0", {63'd0, s_ack0}, 64'd1);
    step(); chk("t1_ov_n1", {63'd0, s_ov}, 64'd0);
    step(); chk("t1_ov_n2", {63'd0, s_ov}, 64'd1);
            chk("t1_data", {32'd0, s_od}, 64'h3F800000);
            chk("t1_id", {63'd0, s_oid}, 64'd0);
    step(); chk("t1_single", {63'd0, s_ov}, 64'd0);

    // Fairness and full throughput.
    do_reset();
    ack_log.delete();
    for (int i = 0; i < 8; i++) begin
      src0_q.push_back(32'h20000000);
      src1_q.push_back(32'h40000000);
    end
    n = 0;
    while ((src0_q.size() > 0 || src1_q.size() > 0) && n < 64) begin
      step();
      n++;
    end
    chk("t2_tput", 64'(n), 64'd16);
    for (int i = 0; i < ack_log.size(); i++)
      chk("t2_alt", 64'(ack_log[i]), 64'(i % 2));
    drain();

    // Back-pressure for 3 cycles.
    for (int i = 0; i < 6; i++) src1_q.push_back(32'h10000000);
    rdy = 1'b1; step(); step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_ov", {63'd0, s_ov}, 64'd1);
      chk("t3_stall_od", {32'd0, s_od}, 64'h3F000000);
    end
    drain();

    // Idle bubble.
    src1_q.push_back(32'h00000000);
    step(); chk("t4_ack1", {62'd0, s_ack0, s_ack1}, 64'd1);
    step(); chk("t4_ov_n1", {63'd0, s_ov}, 64'd0);
    step(); chk("t4_ov", {63'd0, s_ov}, 64'd1);
            chk("t4_data", {32'd0, s_od}, 64'd0);
            chk("t4_id", {63'd0, s_oid}, 64'd1);
    step(); chk("t4_after", {63'd0, s_ov}, 64'd0);
    step(); chk("t4_after2", {63'd0, s_ov}, 64'd0);

    // Random operands and back-pressure.
    for (int c = 0; c < 400; c++) begin
      if (src0_q.size() < 2 && $urandom_range(0, 2) == 0) src0_q.push_back(tab[$urandom_range(0, 8)]);
      if (src1_q.size() < 2 && $urandom_range(0, 2) == 0) src1_q.push_back(tab[$urandom_range(0, 8)]);
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Asynchronous reset with both stages full.
    for (int i = 0; i < 4; i++) begin
      src0_q.push_back(32'h30000000);
      src1_q.push_back(32'hE0000000);
    end
    rdy = 1'b0;
    step(); step(); step();
    chk("t6_pre_ov", {63'd0, s_ov}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_ov", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_noack", {62'd0, ack0, ack1}, 64'd0);
    do_reset();
    ack_log.delete();
    src0_q.push_back(32'h20000000);
    src1_q.push_back(32'h40000000);
    rdy = 1'b1;
    step();
    chk("t6_first_ack0", {62'd0, s_ack0, s_ack1}, 64'd2);
    drain();
    chk("t6_order", 64'(ack_log.size() == 2 && ack_log[0] == 0 && ack_log[1] == 1), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
